// File: rtl/alarm_trigger.sv
// ============================================================================
// Module   : alarm_trigger
// Purpose  : Decodes the 12-hour BCD alarm time into minutes-of-day and runs
//            the ring / snooze / stop state machine for the buzzer path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_trigger #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 9
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic [15:0] i_Alarm_Time,
    input  logic        i_Alarm_PM,
    input  logic [16:0] i_Current_Seconds,
    input  logic        i_Second_Tick,
    input  logic        i_Alarm_Enable,
    input  logic        i_Snooze,
    input  logic        i_Stop,
    output logic        o_Alarm_Active,
    output logic        o_Snoozing,
    output logic [10:0] o_Alarm_Minutes,
    output logic        o_Decode_Error
);

    localparam int c_RW = $clog2(RING_SECONDS + 1);
    localparam logic [c_RW-1:0] c_RING_LAST = c_RW'(RING_SECONDS - 1);
    localparam logic [c_RW-1:0] c_RING_MAX  = c_RW'(RING_SECONDS);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RINGING = 2'd1;
    localparam logic [1:0] c_SNOOZE  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_alarm_active;
    logic            r_snoozing;
    logic [10:0]     r_alarm_minutes;
    logic            r_decode_error;
    logic [c_RW-1:0] r_ring_cnt;
    logic [10:0]     r_snooze_target;

    logic            w_clr_ring;
    logic            w_inc_ring;
    logic            w_load_snooze;

    // Alarm time decode
    logic [3:0]  w_h1, w_h2, w_m1, w_m2;
    logic [4:0]  w_h12;
    logic [4:0]  w_h24;
    logic        w_legal;
    logic [10:0] w_minutes;

    assign w_h1 = i_Alarm_Time[15:12];
    assign w_h2 = i_Alarm_Time[11:8];
    assign w_m1 = i_Alarm_Time[7:4];
    assign w_m2 = i_Alarm_Time[3:0];

    // H1 is only legal as 0 or 1, so its low bit alone selects the tens value
    assign w_h12   = (w_h1[0] ? 5'd10 : 5'd0) + {1'b0, w_h2};
    assign w_legal = (w_h1 <= 4'd1) && (w_h2 <= 4'd9) && (w_h12 >= 5'd1) &&
                     (w_h12 <= 5'd12) && (w_m1 <= 4'd5) && (w_m2 <= 4'd9);
    assign w_h24   = (w_h12 == 5'd12) ? (i_Alarm_PM ? 5'd12 : 5'd0)
                                      : (w_h12 + (i_Alarm_PM ? 5'd12 : 5'd0));
    assign w_minutes = ({6'd0, w_h24} * 11'd60) + ({7'd0, w_m1} * 11'd10) + {7'd0, w_m2};

    // Match events
    logic w_alarm_hit;
    logic w_snooze_hit;

    assign w_alarm_hit  = i_Second_Tick && i_Alarm_Enable && !r_decode_error &&
                          (i_Current_Seconds == ({6'd0, r_alarm_minutes} * 17'd60));
    assign w_snooze_hit = i_Second_Tick &&
                          (i_Current_Seconds == ({6'd0, r_snooze_target} * 17'd60));

    // Snooze target, wrapped past midnight
    logic [10:0] w_cur_min;
    logic [11:0] w_snz_sum;
    logic [10:0] w_snz_target;

    assign w_cur_min    = 11'(i_Current_Seconds / 17'd60);
    assign w_snz_sum    = {1'b0, w_cur_min} + 12'(SNOOZE_MINUTES);
    assign w_snz_target = (w_snz_sum >= 12'd1440) ? 11'(w_snz_sum - 12'd1440)
                                                  : 11'(w_snz_sum);

    always_comb begin
        w_next_state  = r_state;
        w_clr_ring    = 1'b0;
        w_inc_ring    = 1'b0;
        w_load_snooze = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_alarm_hit && !i_Stop) begin
                    w_next_state = c_RINGING;
                    w_clr_ring   = 1'b1;
                end
            end
            c_RINGING: begin
                if (i_Stop || !i_Alarm_Enable) begin
                    w_next_state = c_IDLE;
                end else if (i_Snooze) begin
                    w_next_state  = c_SNOOZE;
                    w_load_snooze = 1'b1;
                end else if (i_Second_Tick) begin
                    w_inc_ring = 1'b1;
                    if (r_ring_cnt >= c_RING_LAST) begin
                        w_next_state = c_IDLE;
                    end
                end
            end
            c_SNOOZE: begin
                if (i_Stop || !i_Alarm_Enable) begin
                    w_next_state = c_IDLE;
                end else if (w_snooze_hit || w_alarm_hit) begin
                    w_next_state = c_RINGING;
                    w_clr_ring   = 1'b1;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            r_state         <= c_IDLE;
            r_alarm_active  <= 1'b0;
            r_snoozing      <= 1'b0;
            r_alarm_minutes <= 11'd0;
            r_decode_error  <= 1'b0;
            r_ring_cnt      <= '0;
            r_snooze_target <= 11'd0;
        end else begin
            r_state        <= w_next_state;
            r_alarm_active <= (w_next_state == c_RINGING);
            r_snoozing     <= (w_next_state == c_SNOOZE);
            r_decode_error <= !w_legal;
            if (w_legal) begin
                r_alarm_minutes <= w_minutes;
            end
            if (w_clr_ring) begin
                r_ring_cnt <= '0;
            end else if (w_inc_ring && (r_ring_cnt != c_RING_MAX)) begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
            end
            if (w_load_snooze) begin
                r_snooze_target <= w_snz_target;
            end
        end
    end

    assign o_Alarm_Active  = r_alarm_active;
    assign o_Snoozing      = r_snoozing;
    assign o_Alarm_Minutes = r_alarm_minutes;
    assign o_Decode_Error  = r_decode_error;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
// Module   : tb_alarm_trigger
// Purpose  : Self-checking bench for alarm_trigger (decode table + FSM flows).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alarm_time;
    logic        alarm_pm;
    logic [16:0] cur_secs;
    logic        tick;
    logic        enable;
    logic        snooze;
    logic        stop;
    logic        active;
    logic        snoozing;
    logic [10:0] minutes;
    logic        dec_err;

    always #100 clk = ~clk;

    alarm_trigger #(
        .RING_SECONDS   (60),
        .SNOOZE_MINUTES (9)
    ) dut (
        .i_Clk_5MHz        (clk),
        .i_Reset           (rst),
        .i_Alarm_Time      (alarm_time),
        .i_Alarm_PM        (alarm_pm),
        .i_Current_Seconds (cur_secs),
        .i_Second_Tick     (tick),
        .i_Alarm_Enable    (enable),
        .i_Snooze          (snooze),
        .i_Stop            (stop),
        .o_Alarm_Active    (active),
        .o_Snoozing        (snoozing),
        .o_Alarm_Minutes   (minutes),
        .o_Decode_Error    (dec_err)
    );

    typedef struct {
        logic        act;
        logic        snz;
        logic [10:0] min;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] t;
        logic        pm;
        logic [10:0] min;
        logic        err;
    } dec_vec_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Queue the expectation, clock once, then compare what the DUT registered
    task automatic step(input string name, input logic act, input logic snz,
                        input logic [10:0] min, input logic err);
        exp_t  e;
        string n;
        e.act = act; e.snz = snz; e.min = min; e.err = err;
        sb_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        tick   = 1'b0;
        stop   = 1'b0;
        snooze = 1'b0;
        e = sb_q.pop_front();
        n = name_q.pop_front();
        n_checks++;
        if (active !== e.act || snoozing !== e.snz || minutes !== e.min || dec_err !== e.err) begin
            n_errors++;
            $display("FAIL %s: got act=%b snz=%b min=%0d err=%b, want act=%b snz=%b min=%0d err=%b",
                     n, active, snoozing, minutes, dec_err, e.act, e.snz, e.min, e.err);
        end
    endtask

    task automatic do_tick(input logic [16:0] s);
        tick     = 1'b1;
        cur_secs = s;
    endtask

    dec_vec_t dec_tab[8];

    initial begin
        dec_tab[0] = '{16'h0630, 1'b0, 11'd390,  1'b0};
        dec_tab[1] = '{16'h1200, 1'b0, 11'd0,    1'b0};
        dec_tab[2] = '{16'h1200, 1'b1, 11'd720,  1'b0};
        dec_tab[3] = '{16'h1159, 1'b1, 11'd1439, 1'b0};
        dec_tab[4] = '{16'h1345, 1'b0, 11'd1439, 1'b1};
        dec_tab[5] = '{16'h0000, 1'b0, 11'd1439, 1'b1};
        dec_tab[6] = '{16'h0960, 1'b0, 11'd1439, 1'b1};
        dec_tab[7] = '{16'h0105, 1'b1, 11'd785,  1'b0};

        rst = 1'b1; alarm_time = 16'h0630; alarm_pm = 1'b0; cur_secs = '0;
        tick = 1'b0; enable = 1'b0; snooze = 1'b0; stop = 1'b0;
        step("reset", 1'b0, 1'b0, 11'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            alarm_time = dec_tab[i].t;
            alarm_pm   = dec_tab[i].pm;
            step($sformatf("decode[%0d]", i), 1'b0, 1'b0, dec_tab[i].min, dec_tab[i].err);
        end

        // Trigger gating
        alarm_time = 16'h0630; alarm_pm = 1'b0; enable = 1'b1;
        step("arm", 1'b0, 1'b0, 11'd390, 1'b0);
        enable = 1'b0; do_tick(17'd23400);
        step("trig_disabled", 1'b0, 1'b0, 11'd390, 1'b0);
        enable = 1'b1; do_tick(17'd23400); stop = 1'b1;
        step("trig_with_stop", 1'b0, 1'b0, 11'd390, 1'b0);
        do_tick(17'd23400);
        step("trig", 1'b1, 1'b0, 11'd390, 1'b0);

        // Snooze and re-ring at target 399
        cur_secs = 17'd23405; snooze = 1'b1;
        step("snooze", 1'b0, 1'b1, 11'd390, 1'b0);
        do_tick(17'd23880); snooze = 1'b1;
        step("snooze_wait", 1'b0, 1'b1, 11'd390, 1'b0);
        do_tick(17'd23940);
        step("snooze_ring", 1'b1, 1'b0, 11'd390, 1'b0);

        // Timeout: 60 ticks with idle cycles in between
        for (int i = 1; i <= 60; i++) begin
            do_tick(17'(23940 + i));
            step($sformatf("timeout_tick%0d", i), (i < 60), 1'b0, 11'd390, 1'b0);
            step($sformatf("timeout_gap%0d", i), (i < 60), 1'b0, 11'd390, 1'b0);
        end
        do_tick(17'd23401);
        step("no_retrigger", 1'b0, 1'b0, 11'd390, 1'b0);

        // Midnight wrap
        alarm_time = 16'h1155; alarm_pm = 1'b1;
        step("decode_1435", 1'b0, 1'b0, 11'd1435, 1'b0);
        do_tick(17'd86100);
        step("ring_1435", 1'b1, 1'b0, 11'd1435, 1'b0);
        cur_secs = 17'd86110; snooze = 1'b1;
        step("snooze_wrap", 1'b0, 1'b1, 11'd1435, 1'b0);
        do_tick(17'd180);
        step("wrap_wait", 1'b0, 1'b1, 11'd1435, 1'b0);
        do_tick(17'd240);
        step("wrap_ring", 1'b1, 1'b0, 11'd1435, 1'b0);

        // Stop wins over snooze
        stop = 1'b1; snooze = 1'b1;
        step("stop_snooze", 1'b0, 1'b0, 11'd1435, 1'b0);

        // Enable low ends ringing
        do_tick(17'd86100);
        step("ring_again", 1'b1, 1'b0, 11'd1435, 1'b0);
        enable = 1'b0;
        step("enable_low", 1'b0, 1'b0, 11'd1435, 1'b0);
        enable = 1'b1;

        // Reset while snoozing
        do_tick(17'd86100);
        step("ring_pre_rst", 1'b1, 1'b0, 11'd1435, 1'b0);
        cur_secs = 17'd86105; snooze = 1'b1;
        step("snooze_pre_rst", 1'b0, 1'b1, 11'd1435, 1'b0);
        rst = 1'b1;
        step("reset_snooze", 1'b0, 1'b0, 11'd0, 1'b0);
        rst = 1'b0; do_tick(17'd240);
        step("old_target_quiet", 1'b0, 1'b0, 11'd1435, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumer of the alarm-time path. Decodes the packed 12-hour BCD alarm time and AM/PM flag back into minutes-of-day, and compares it against the running time-of-day seconds count.
- Runs the ring / snooze / stop state machine that drives the buzzer and LED logic.
- Sits between the alarm-time setter, the main clock counter and the buzzer driver, in the 5 MHz domain.

Parameters:
- RING_SECONDS, default 60: number of second ticks the alarm rings before it auto-stops.
- SNOOZE_MINUTES, default 9: snooze delay in minutes.

Ports:
- i_Clk_5MHz  in  1  system clock.
- i_Reset  in  1  reset; synchronous, active-high.
- i_Alarm_Time  in  16  packed BCD {H1,H2,M1,M2}, 12-hour format; hours 01..12, minutes 00..59.
- i_Alarm_PM  in  1  1 = PM.
- i_Current_Seconds  in  17  time of day in seconds, 0..86399.
- i_Second_Tick  in  1  one-cycle pulse, once per second, coincident with i_Current_Seconds update.
- i_Alarm_Enable  in  1  level; alarm armed.
- i_Snooze  in  1  one-cycle pulse (debounced button).
- i_Stop  in  1  one-cycle pulse (debounced button).
- o_Alarm_Active  out  1  alarm ringing.
- o_Snoozing  out  1  snooze pending.
- o_Alarm_Minutes  out  11  decoded alarm minutes-of-day, 0..1439.
- o_Decode_Error  out  1  current i_Alarm_Time/PM is not a legal time.

Behaviour:

Reset:
- State IDLE.
- o_Alarm_Active = 0, o_Snoozing = 0, o_Alarm_Minutes = 0, o_Decode_Error = 0.
- Ring counter = 0, snooze target = 0.
- Reset asserted in any state (including RINGING or SNOOZE) returns to IDLE on the next edge.

Decode (registered, 1-cycle latency):
- h12 = 10*H1 + H2.
- Legal only if all of: H1 <= 1, H2 <= 9, h12 in 1..12, M1 <= 5, M2 <= 9.
- h24 = (h12 == 12) ? (PM ? 12 : 0) : h12 + (PM ? 12 : 0).
- Minutes = h24*60 + 10*M1 + M2, computed in 11 bits; result is never >= 1440.
- Illegal input: o_Alarm_Minutes holds its previous value and o_Decode_Error = 1. Matching is suppressed while the error is set.

Match events (single-cycle, combinational from registered values):
- alarm_hit = i_Second_Tick & i_Alarm_Enable & !o_Decode_Error & (i_Current_Seconds == o_Alarm_Minutes*60).
- snooze_hit = i_Second_Tick & (i_Current_Seconds == snooze_target*60).
- Matching is exact equality only. Minutes skipped by clock setting never fire.

FSM (all outputs registered, asserted the cycle after the causing event):
- IDLE:
  - alarm_hit -> RINGING, ring counter cleared.
  - i_Stop or i_Snooze in the same cycle as alarm_hit: Stop suppresses the ring (stay IDLE); Snooze is ignored.
- RINGING (o_Alarm_Active = 1):
  - Priority: i_Stop > !i_Alarm_Enable > i_Snooze > timeout.
  - i_Stop -> IDLE.
  - Enable low -> IDLE.
  - i_Snooze -> SNOOZE; snooze_target = (i_Current_Seconds/60 + SNOOZE_MINUTES) mod 1440.
  - Each i_Second_Tick increments the ring counter. On the tick that brings the count to RING_SECONDS -> IDLE.
  - alarm_hit while RINGING is ignored; the counter is not restarted.
- SNOOZE (o_Snoozing = 1):
  - i_Stop or enable low -> IDLE.
  - snooze_hit or alarm_hit -> RINGING, ring counter cleared.
  - i_Snooze is ignored.
- Snooze target wraps past midnight: 1439 + 9 -> 8.
- o_Alarm_Active and o_Snoozing are never both 1.
- Ring counter width: clog2(RING_SECONDS+1); saturates and never wraps.

Test Plan:
- Decode: i_Alarm_Time = 0x0630, PM = 0 -> o_Alarm_Minutes = 390 one cycle later. 0x1200/AM -> 0. 0x1200/PM -> 720. 0x1159/PM -> 1439. 0x1345 -> o_Decode_Error = 1 and minutes held at 1439.
- Trigger: alarm 390, enable = 1, tick with i_Current_Seconds = 23400 -> o_Alarm_Active = 1 next cycle. Same tick with enable = 0, or with i_Stop asserted -> stays 0.
- Snooze: ringing, i_Snooze at seconds 23405 -> o_Snoozing = 1, target 399. Tick at 23940 -> o_Alarm_Active = 1, o_Snoozing = 0.
- Timeout: ringing with no buttons -> o_Alarm_Active drops after exactly 60 ticks. Another tick at the same minute does not retrigger.
- Midnight wrap: alarm 0x1155/PM (1435) rings at 86100; i_Snooze at 86110 -> target 4. Ring resumes on the tick at i_Current_Seconds = 240.
- Priority / reset: i_Stop and i_Snooze in the same cycle while ringing -> IDLE, both outputs 0. i_Reset mid-SNOOZE -> all outputs 0; a later tick at the old snooze target does not ring.
